// File: rtl/gnrl_elastic_buf.sv
// Elastic buffer: DEPTH-entry valid/ready slice with registered handshake, level and almost-full outputs.
// Optional synchronous flush port enabled by defining GNRL_ELASTIC_BUF_FLUSH_EN.
module gnrl_elastic_buf #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned AFULL_TH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       din_vld_i,
  output logic                       din_rdy_o,
  output logic [DW-1:0]              dout_o,
  output logic                       dout_vld_o,
  input  logic                       dout_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       afull_o
`ifdef GNRL_ELASTIC_BUF_FLUSH_EN
  ,
  input  logic                       flush_i
`endif
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [LW-1:0] lvl_nxt;
  logic          push;
  logic          pop;
  logic          flush;

`ifdef GNRL_ELASTIC_BUF_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign push = din_vld_i & din_rdy_o;
  assign pop  = dout_vld_o & dout_rdy_i;

  // Head entry drives the output; it only changes on pop, so it holds under backpressure.
  assign dout_o = mem[rd_ptr];

  // Next pointers and occupancy; pointers wrap at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    lvl_nxt    = level_o + LW'(push) - LW'(pop);
    if (push) begin
      wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    end
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      lvl_nxt    = '0;
    end
  end

  // Control state; handshake flags are derived from the next level so they are registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      din_rdy_o  <= 1'b1;
      dout_vld_o <= 1'b0;
      afull_o    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      level_o    <= lvl_nxt;
      din_rdy_o  <= (lvl_nxt != LW'(DEPTH));
      dout_vld_o <= (lvl_nxt != '0);
      afull_o    <= (lvl_nxt >= LW'(AFULL_TH));
    end
  end

  // Storage; a push coinciding with flush is dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= din_i;
    end
  end

endmodule
